// File: rtl/pipelined_adder_activity.sv
// Multi-stage sliced carry-chain adder with valid/ready flow control and a
// saturating Hamming-distance toggle counter on the transferred results.
module pipelined_adder_activity #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    input  logic             count_clr,
    output logic [CNT_W-1:0] toggle_count,
    output logic             count_sat
);
    localparam int SW = WIDTH / STAGES;
    localparam int DW = $clog2(WIDTH + 2);
    localparam int TW = ((CNT_W > DW) ? CNT_W : DW) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [SW:0] add_slice(input logic [SW-1:0] x,
                                              input logic [SW-1:0] y,
                                              input logic          ci);
        return {1'b0, x} + {1'b0, y} + {{SW{1'b0}}, ci};
    endfunction

    function automatic logic [DW-1:0] popcount(input logic [WIDTH:0] v);
        logic [DW-1:0] n;
        n = '0;
        for (int i = 0; i <= WIDTH; i++) n = n + DW'(v[i]);
        return n;
    endfunction

    // Returns {overflow, clamped count}.
    function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [DW-1:0]    inc);
        logic [TW-1:0] t;
        t = TW'(base) + TW'(inc);
        if (t > TW'(CNT_MAX)) return {1'b1, CNT_MAX};
        return {1'b0, t[CNT_W-1:0]};
    endfunction

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int RW = WIDTH - k * SW;   // operand bits not yet added
        localparam int LW = (k + 1) * SW;     // sum bits resolved after this stage

        logic [RW-1:0] a_src;
        logic [RW-1:0] b_src;
        logic          c_src;
        logic          v_src;
        logic [SW:0]   slice;
        logic [LW-1:0] s_nxt;
        logic          vld_r;
        logic [LW-1:0] s_r;
        logic          c_r;

        if (k == 0) begin : g_head
            assign a_src = a;
            assign b_src = b;
            assign c_src = cin;
            assign v_src = in_valid;
            assign s_nxt = slice[SW-1:0];
        end else begin : g_body
            assign a_src = g_stage[k-1].g_fwd.a_r;
            assign b_src = g_stage[k-1].g_fwd.b_r;
            assign c_src = g_stage[k-1].c_r;
            assign v_src = g_stage[k-1].vld_r;
            assign s_nxt = {slice[SW-1:0], g_stage[k-1].s_r};
        end

        assign slice = add_slice(a_src[SW-1:0], b_src[SW-1:0], c_src);

        always_ff @(posedge clk) begin
            if (rst)      vld_r <= 1'b0;
            else if (adv) vld_r <= v_src;
        end

        // Data registers only load on real tokens so bubbles never disturb them.
        if (k < STAGES - 1) begin : g_fwd
            logic [RW-SW-1:0] a_r;
            logic [RW-SW-1:0] b_r;
            always_ff @(posedge clk) begin
                if (adv && v_src) begin
                    a_r <= a_src[RW-1:SW];
                    b_r <= b_src[RW-1:SW];
                    s_r <= s_nxt;
                    c_r <= slice[SW];
                end
            end
        end else begin : g_out
            always_ff @(posedge clk) begin
                if (rst) begin
                    s_r <= '0;
                    c_r <= 1'b0;
                end else if (adv && v_src) begin
                    s_r <= s_nxt;
                    c_r <= slice[SW];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_r;
    assign sum       = g_stage[STAGES-1].s_r;
    assign carry     = g_stage[STAGES-1].c_r;

    logic [WIDTH:0]   res;
    logic [WIDTH:0]   prev;
    logic             xfer;
    logic [CNT_W-1:0] base;
    logic [CNT_W:0]   acc;

    assign res  = {carry, sum};
    assign xfer = out_valid && out_ready;
    assign base = count_clr ? {CNT_W{1'b0}} : toggle_count;
    assign acc  = sat_add(base, popcount(res ^ prev));

    // Toggle accounting stage: a clear takes effect before a same-cycle transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev         <= '0;
            toggle_count <= '0;
            count_sat    <= 1'b0;
        end else if (xfer) begin
            prev         <= res;
            toggle_count <= acc[CNT_W-1:0];
            count_sat    <= (count_sat && !count_clr) || acc[CNT_W];
        end else if (count_clr) begin
            toggle_count <= '0;
            count_sat    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pipelined_adder_activity.sv
// Scoreboard bench for pipelined_adder_activity: directed vectors push expected
// {carry,sum} on acceptance, a negedge monitor pops and compares on transfer.
module tb_pipelined_adder_activity;
    localparam int WIDTH  = 8;
    localparam int STAGES = 2;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             count_clr;
    logic [CNT_W-1:0] toggle_count;
    logic             count_sat;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [WIDTH:0] exp_q[$];
    int             seen_q[$];

    logic [WIDTH-1:0] b2b_a   [4] = '{8'd1, 8'd3, 8'd5, 8'd7};
    logic [WIDTH-1:0] b2b_b   [4] = '{8'd2, 8'd4, 8'd6, 8'd8};
    logic [WIDTH:0]   b2b_exp [4] = '{9'h003, 9'h007, 9'h00B, 9'h00F};

    pipelined_adder_activity #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry(carry), .count_clr(count_clr),
        .toggle_count(toggle_count), .count_sat(count_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge unless reset wins.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stale_token: got 0x%0h, expected no output", {carry, sum});
            end else begin
                chk("result", {carry, sum}, exp_q.pop_front());
                seen_q.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic ci, input logic [WIDTH:0] exp,
                        output int stalls, output int acc_cyc);
        int n = 0;
        if (!clk) begin
            @(posedge clk);
            #1;
        end
        a = x; b = y; cin = ci; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=0, expected 1 within 100 cycles");
        end else begin
            exp_q.push_back(exp);
        end
        stalls  = n;
        acc_cyc = cyc + 1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_ov();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("wait_out_valid", out_valid, 1);
    endtask

    task automatic clr_idle();
        @(posedge clk);
        #1 count_clr = 1'b1;
        @(posedge clk);
        #1 count_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_sum"}, sum, 0);
        chk({tag, "_carry"}, carry, 0);
        chk({tag, "_toggle_count"}, toggle_count, 0);
        chk({tag, "_count_sat"}, count_sat, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        int st;
        int ac;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        out_ready = 1'b1; count_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_state("reset");

        // Carry across slices, then full ripple
        seen_q.delete();
        send(8'h0F, 8'h01, 1'b0, 9'h010, st, ac);
        drain();
        chk("latency", seen_q[0] - ac, STAGES - 1);
        chk("count_slice_carry", toggle_count, 1);
        send(8'hFF, 8'h01, 1'b0, 9'h100, st, ac);
        drain();
        chk("count_full_ripple", toggle_count, 3);
        send(8'h80, 8'h7F, 1'b1, 9'h100, st, ac);
        drain();
        chk("count_unchanged", toggle_count, 3);

        // Back-to-back throughput
        seen_q.delete();
        for (int i = 0; i < 4; i++) begin
            send(b2b_a[i], b2b_b[i], 1'b0, b2b_exp[i], st, ac);
            chk("b2b_stall", st, 0);
        end
        drain();
        for (int i = 1; i < 4; i++) chk("b2b_spacing", seen_q[i] - seen_q[i-1], 1);
        chk("count_b2b", toggle_count, 10);

        clr_idle();
        chk("clr_idle_count", toggle_count, 0);
        chk("clr_idle_sat", count_sat, 0);

        // Backpressure: result held, counted once on release
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b0, 9'h046, st, ac);
        wait_ov();
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_result", {carry, sum}, 9'h046);
            chk("bp_count", toggle_count, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();
        chk("bp_count_once", toggle_count, 3);

        // Saturation and clear
        clr_idle();
        send(8'h00, 8'h00, 1'b0, 9'h000, st, ac);
        drain();
        chk("sat_pre_count", toggle_count, 3);
        clr_idle();
        chk("sat_clr_count", toggle_count, 0);
        send(8'hFF, 8'hFF, 1'b1, 9'h1FF, st, ac);
        drain();
        chk("sat_count_9", toggle_count, 9);
        chk("sat_flag_0", count_sat, 0);
        send(8'h00, 8'h00, 1'b0, 9'h000, st, ac);
        drain();
        chk("sat_count_max", toggle_count, 15);
        chk("sat_flag_1", count_sat, 1);
        send(8'hFF, 8'hFF, 1'b1, 9'h1FF, st, ac);
        drain();
        chk("sat_count_hold", toggle_count, 15);
        chk("sat_flag_sticky", count_sat, 1);

        @(posedge clk);
        #1 out_ready = 1'b0;
        send(8'h00, 8'h00, 1'b0, 9'h000, st, ac);
        wait_ov();
        @(posedge clk);
        #1 begin out_ready = 1'b1; count_clr = 1'b1; end
        @(posedge clk);
        #1 count_clr = 1'b0;
        @(negedge clk);
        chk("clr_xfer_count", toggle_count, 9);
        chk("clr_xfer_sat", count_sat, 0);

        // Reset with two tokens in flight
        send(8'h01, 8'h01, 1'b0, 9'h002, st, ac);
        send(8'h02, 8'h02, 1'b0, 9'h004, st, ac);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk_reset_state("midrst");
        repeat (6) begin
            @(negedge clk);
            chk("midrst_no_stale", out_valid, 0);
        end
        send(8'h55, 8'hAA, 1'b1, 9'h100, st, ac);
        drain();
        chk("post_rst_count", toggle_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/pipelined_adder_activity.md
Name: pipelined_adder_activity

Overview:
- Parametrised, pipelined WIDTH-bit adder with carry-in, generalising the single-bit full-adder cell to a multi-stage sliced carry chain with valid/ready flow control.
- Built-in switching-activity counter: accumulates the Hamming distance between successive transferred results, giving the power-estimation flow an on-chip toggle metric for the adder datapath.

Parameters:
- WIDTH, 8, operand/sum width in bits; must be divisible by STAGES.
- STAGES, 2, pipeline stages; slice width SW = WIDTH/STAGES; range 1..WIDTH.
- CNT_W, 16, toggle counter width in bits.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  registered sum.
- carry  output  1  registered carry-out.
- count_clr  input  1  synchronous clear of toggle counter and saturation flag.
- toggle_count  output  CNT_W  accumulated result toggles.
- count_sat  output  1  sticky flag, set when toggle_count saturates.

Behaviour:
- Reset (rst=1 at clk edge): all stage valids, out_valid, sum, carry, toggle_count, count_sat and the previous-result register go to 0. Reset wins over every other input, including mid-pipeline data, which is discarded.
- Advance: adv = !out_valid || out_ready. in_ready = adv (combinational). When adv=0 the whole pipeline freezes and every stage register holds. Bubbles are not compressed.
- Acceptance: occurs when in_valid && in_ready.
- Slicing: stage k (k=0..STAGES-1) adds bits [k*SW +: SW] of A and B plus the carry registered by stage k-1 (stage 0 uses cin).
- Data movement: higher-slice operand bits and lower-slice sum bits travel with the token through stage registers.
- Latency: a token accepted at edge t produces out_valid=1 after edge t+STAGES-1 when no stall occurs. For STAGES=1, out_valid is visible the cycle after acceptance.
- Output: {carry,sum} = a + b + cin, exact modulo 2^(WIDTH+1). Held stable while out_valid && !out_ready.
- Transfer: occurs when out_valid && out_ready.
- Toggle accounting: on each transfer, d = popcount({carry,sum} XOR prev). Then prev <= {carry,sum} and toggle_count <= toggle_count + d.
- prev is WIDTH+1 bits and resets to 0, so the first transfer counts against all-zeros.
- Saturation: if the sum exceeds 2^CNT_W-1, toggle_count = 2^CNT_W-1 and count_sat <= 1 (sticky). Once saturated, the count stays at max.
- count_clr: toggle_count <= 0 and count_sat <= 0. If a transfer occurs in the same cycle, the clear applies first, so toggle_count <= d (saturated at max), and prev still updates.
- Independence: count_clr has no effect on the pipeline datapath.
- No output toggles spuriously: sum and carry change only when a new token reaches the output register.

Test Plan:
- Carry across slices: WIDTH=8, STAGES=2, a=0x0F, b=0x01, cin=0, out_ready=1 -> out_valid one cycle after acceptance, sum=0x10, carry=0, toggle_count=1.
- Full carry ripple: next a=0xFF, b=0x01, cin=0 -> sum=0x00, carry=1. {1,0x00} vs {0,0x10} gives toggle_count=3. Then a=0x80, b=0x7F, cin=1 -> sum=0x00, carry=1, count unchanged at 3.
- Back-to-back throughput: 4 consecutive tokens (1+2, 3+4, 5+6, 7+8, cin=0) -> in_ready stays 1, out_valid high for 4 consecutive cycles, sums 3, 7, 11, 15 in order.
- Backpressure: out_ready=0 with a result pending -> in_ready=0, sum/carry/out_valid held for 5 cycles with no count change. Then out_ready=1 -> single transfer, counted once.
- Saturation and clear: CNT_W=4, alternate results 0x1FF and 0x000 (d=9 each) -> toggle_count=9, then 15 with count_sat=1. Assert count_clr together with a transfer of d=9 -> toggle_count=9, count_sat=0.
- Reset mid-operation: rst=1 for one cycle with 2 tokens in flight -> next cycle out_valid=0, sum=0, toggle_count=0, in_ready=1. No stale token ever emerges.
